// File: rtl/aes_key_expand.sv
// AES key schedule: expands a 128/192/256-bit key into round keys one word per cycle.
// Round keys are served on a combinational read port and become valid progressively.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // multiplicative inverse as a^254, then the affine transform
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        s = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    input  logic [3:0]   subkey_addr,
    output logic [127:0] subkey,
    output logic         subkey_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] w [60];
    logic [15:0] valid_q;
    logic [7:0]  rcon_q;
    logic [5:0]  i_q;
    logic [2:0]  j_q;
    logic [3:0]  nk_q;
    logic [3:0]  nr_q;
    logic [5:0]  last_q;

    logic        load;
    logic        step;
    logic [3:0]  nk_d;
    logic [3:0]  nr_d;
    logic [5:0]  last_d;

    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_w;
    logic [5:0]  base;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    // key length decode into words-per-key, rounds and last word index
    always_comb begin
        nk_d   = 4'd4;
        nr_d   = 4'd10;
        last_d = 6'd43;
        case (key_len)
            2'b10: begin
                nk_d   = 4'd6;
                nr_d   = 4'd12;
                last_d = 6'd51;
            end
            2'b11: begin
                nk_d   = 4'd8;
                nr_d   = 4'd14;
                last_d = 6'd59;
            end
            default: begin
                nk_d   = 4'd4;
                nr_d   = 4'd10;
                last_d = 6'd43;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state and datapath strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start && key_len != 2'b00) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (i_q == last_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign prev   = w[i_q - 6'd1];
    assign back   = w[i_q - {2'b00, nk_q}];
    assign sub_in = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_sbox u_sb0 (.a(sub_in[31:24]), .s(sub_out[31:24]));
    aes_sbox u_sb1 (.a(sub_in[23:16]), .s(sub_out[23:16]));
    aes_sbox u_sb2 (.a(sub_in[15:8]),  .s(sub_out[15:8]));
    aes_sbox u_sb3 (.a(sub_in[7:0]),   .s(sub_out[7:0]));

    // temp word: rotated/substituted at key boundaries, substituted mid-key for 256
    always_comb begin
        temp = prev;
        unique case (1'b1)
            (j_q == 3'd0):
                temp = sub_out ^ {rcon_q, 24'h0};
            (nk_q == 4'd8 && j_q == 3'd4):
                temp = sub_out;
            default:
                temp = prev;
        endcase
    end

    assign new_w = back ^ temp;

    // word store, counters, rcon and per-round valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 60; k++) w[k] <= 32'h0;
            valid_q <= '0;
            rcon_q  <= 8'h00;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            last_q  <= 6'd0;
        end else if (load) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_d) w[k] <= key_in[255-32*k -: 32];
            end
            valid_q <= {14'b0, (nk_d == 4'd8), 1'b1};
            rcon_q  <= 8'h01;
            i_q     <= {2'b00, nk_d};
            j_q     <= 3'd0;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            last_q  <= last_d;
        end else if (step) begin
            w[i_q] <= new_w;
            i_q    <= i_q + 6'd1;
            if ({1'b0, j_q} == nk_q - 4'd1) j_q <= 3'd0;
            else                            j_q <= j_q + 3'd1;
            if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
            if (i_q[1:0] == 2'b11) valid_q[i_q[5:2]] <= 1'b1;
        end
    end

    assign base = {subkey_addr, 2'b00};

    // zero-latency read of the addressed round key
    always_comb begin
        subkey = '0;
        if (subkey_addr != 4'd15)
            subkey = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end

    assign subkey_valid = valid_q[subkey_addr] && (subkey_addr <= nr_q);
    assign busy         = (state_q == EXPAND);
    assign done         = (state_q == DONE);

endmodule
